// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_pkg
// Brief   : RV32I opcodes, sequencer state codes and instruction classes.
// Revision: 1.0
// ============================================================================
package cpu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] FETCH     = 3'd0;
    localparam logic [2:0] DECODE    = 3'd1;
    localparam logic [2:0] EXECUTE   = 3'd2;
    localparam logic [2:0] MEM       = 3'd3;
    localparam logic [2:0] WRITEBACK = 3'd4;
    localparam logic [2:0] TRAP      = 3'd5;

    typedef enum logic [3:0] {
        CLS_R     = 4'd0,
        CLS_I_ALU = 4'd1,
        CLS_LOAD  = 4'd2,
        CLS_STORE = 4'd3,
        CLS_BRANCH= 4'd4,
        CLS_JAL   = 4'd5,
        CLS_JALR  = 4'd6,
        CLS_LUI   = 4'd7,
        CLS_AUIPC = 4'd8
    } instr_class_e;

    function automatic logic is_jump(input instr_class_e c);
        return (c == CLS_JAL) || (c == CLS_JALR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : cpu_sequencer_if
// Brief   : Instruction/data memory request-acknowledge handshakes.
// Revision: 1.0
// ============================================================================
interface cpu_sequencer_if;
    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_we;
    logic dmem_ack;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ack, dmem_ack
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ack, dmem_ack
    );
endinterface
`default_nettype wire

// File: rtl/cpu_sequencer_classifier.sv
`default_nettype none
// ============================================================================
// Module  : opcode_classifier
// Brief   : Combinational RV32I opcode to instruction-class decode.
// Revision: 1.0
// ============================================================================
module opcode_classifier
    import cpu_pkg::*;
(
    input  wire logic [6:0]   i_opcode,
    output instr_class_e      o_class,
    output logic              o_illegal
);

    // Full 7-bit match, so any opcode with [1:0] != 2'b11 lands in default.
    always_comb begin
        o_class   = CLS_R;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_R:      o_class = CLS_R;
            OP_IMM:    o_class = CLS_I_ALU;
            OP_LOAD:   o_class = CLS_LOAD;
            OP_STORE:  o_class = CLS_STORE;
            OP_BRANCH: o_class = CLS_BRANCH;
            OP_JAL:    o_class = CLS_JAL;
            OP_JALR:   o_class = CLS_JALR;
            OP_LUI:    o_class = CLS_LUI;
            OP_AUIPC:  o_class = CLS_AUIPC;
            default:   o_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : cpu_sequencer
// Brief   : Multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK control sequencer
//           with memory handshakes. SEQ_INSTRET_EN adds a retired counter.
// Revision: 1.0
// ============================================================================
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic [6:0]   opcode,
    input  wire logic         branch_taken,
    input  wire logic         stall_in,
    cpu_sequencer_if.master   mem_bus,
    output logic              ir_load,
    output logic              reg_write,
    output logic              pc_write,
    output logic              pc_src,
    output logic              illegal,
    output logic [2:0]        state
`ifdef SEQ_INSTRET_EN
    ,
    output logic [WIDTH-1:0]  instret
`endif
);

    if (WIDTH < 1) begin : g_width_check
        $error("cpu_sequencer: WIDTH must be at least 1");
    end

    logic [2:0]   r_state_q,   w_state_d;
    instr_class_e r_class_q,   w_class_d;
    logic         r_illegal_q, w_illegal_d;

    instr_class_e w_cls;
    logic         w_cls_illegal;

    logic w_imem_req, w_dmem_req, w_dmem_we;
    logic w_ir_load, w_reg_write, w_pc_write, w_pc_src;

    opcode_classifier u_classifier (
        .i_opcode  (opcode),
        .o_class   (w_cls),
        .o_illegal (w_cls_illegal)
    );

    always_ff @(posedge clk) begin : p_state_reg
        if (rst) begin
            r_state_q   <= FETCH;
            r_class_q   <= CLS_R;
            r_illegal_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_class_q   <= w_class_d;
            r_illegal_q <= w_illegal_d;
        end
    end

    always_comb begin : p_next_state
        w_state_d   = r_state_q;
        w_class_d   = r_class_q;
        w_illegal_d = r_illegal_q;
        case (r_state_q)
            FETCH: begin
                if (mem_bus.imem_ack) w_state_d = DECODE;
            end
            DECODE: begin
                if (!stall_in) begin
                    w_class_d = w_cls;
                    if (w_cls_illegal) begin
                        w_state_d   = TRAP;
                        w_illegal_d = 1'b1;
                    end else begin
                        w_state_d   = EXECUTE;
                    end
                end
            end
            EXECUTE: begin
                if (!stall_in) begin
                    case (r_class_q)
                        CLS_BRANCH:          w_state_d = FETCH;
                        CLS_LOAD, CLS_STORE: w_state_d = MEM;
                        default:             w_state_d = WRITEBACK;
                    endcase
                end
            end
            // MEM ignores stall_in so the data handshake always completes.
            MEM: begin
                if (mem_bus.dmem_ack)
                    w_state_d = (r_class_q == CLS_STORE) ? FETCH : WRITEBACK;
            end
            WRITEBACK: begin
                if (!stall_in) w_state_d = FETCH;
            end
            TRAP:    w_state_d = TRAP;
            default: w_state_d = FETCH;
        endcase
    end

    always_comb begin : p_outputs
        w_imem_req  = (r_state_q == FETCH);
        w_dmem_req  = (r_state_q == MEM);
        w_dmem_we   = (r_state_q == MEM) && (r_class_q == CLS_STORE);
        w_ir_load   = 1'b0;
        w_reg_write = 1'b0;
        w_pc_write  = 1'b0;
        w_pc_src    = 1'b0;
        case (r_state_q)
            FETCH: w_ir_load = mem_bus.imem_ack;
            EXECUTE: begin
                if (!stall_in && (r_class_q == CLS_BRANCH)) begin
                    w_pc_write = 1'b1;
                    w_pc_src   = branch_taken;
                end
            end
            MEM: begin
                if (mem_bus.dmem_ack && (r_class_q == CLS_STORE))
                    w_pc_write = 1'b1;
            end
            WRITEBACK: begin
                if (!stall_in) begin
                    w_reg_write = 1'b1;
                    w_pc_write  = 1'b1;
                    w_pc_src    = is_jump(r_class_q);
                end
            end
            default: ;
        endcase
    end

    // Reset masks outputs combinationally so requests drop in the rst cycle itself.
    assign mem_bus.imem_req = w_imem_req  & ~rst;
    assign mem_bus.dmem_req = w_dmem_req  & ~rst;
    assign mem_bus.dmem_we  = w_dmem_we   & ~rst;
    assign ir_load          = w_ir_load   & ~rst;
    assign reg_write        = w_reg_write & ~rst;
    assign pc_write         = w_pc_write  & ~rst;
    assign pc_src           = w_pc_src    & ~rst;
    assign illegal          = r_illegal_q & ~rst;
    assign state            = rst ? FETCH : r_state_q;

`ifdef SEQ_INSTRET_EN
    logic [WIDTH-1:0] r_instret_q, w_instret_d;

    always_comb begin
        w_instret_d = r_instret_q;
        if (w_pc_write) w_instret_d = r_instret_q + WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) r_instret_q <= '0;
        else     r_instret_q <= w_instret_d;
    end

    assign instret = rst ? '0 : r_instret_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_sequencer
// Brief   : Directed cycle tables for cpu_sequencer.
// Revision: 1.0
// ============================================================================
module tb_cpu_sequencer;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = OP_R;
    logic       branch_taken = 1'b0;
    logic       stall_in = 1'b0;
    logic       ir_load, reg_write, pc_write, pc_src, illegal;
    logic [2:0] state;
`ifdef SEQ_INSTRET_EN
    logic [31:0] instret;
`endif

    int checks = 0;
    int failures = 0;
    int exp_retired = 0;

    always #5 clk = ~clk;

    cpu_sequencer_if mem_bus ();

    cpu_sequencer #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .stall_in     (stall_in),
        .mem_bus      (mem_bus),
        .ir_load      (ir_load),
        .reg_write    (reg_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .illegal      (illegal),
        .state        (state)
`ifdef SEQ_INSTRET_EN
        ,
        .instret      (instret)
`endif
    );

    // {imem_req,dmem_req,dmem_we, ir_load,reg_write,pc_write,pc_src, illegal, state}
    logic [10:0] obs;
    assign obs = {mem_bus.imem_req, mem_bus.dmem_req, mem_bus.dmem_we,
                  ir_load, reg_write, pc_write, pc_src, illegal, state};

    // Input vector: {rst, imem_ack, dmem_ack, stall_in, branch_taken}
    task automatic drive(input logic [4:0] v);
        @(negedge clk);
        rst              = v[4];
        mem_bus.imem_ack = v[3];
        mem_bus.dmem_ack = v[2];
        stall_in         = v[1];
        branch_taken     = v[0];
        if (v[4]) exp_retired = 0;
        #1;
    endtask

    task automatic test_reset();
        logic [4:0]  in_v [5];
        logic [10:0] exp_v[5];
        in_v  = '{5'b10000, 5'b10000, 5'b11100, 5'b10000, 5'b00000};
        exp_v = '{11'b000_0000_0_000, 11'b000_0000_0_000, 11'b000_0000_0_000,
                  11'b000_0000_0_000, 11'b100_0000_0_000};
        for (int i = 0; i < 5; i++) begin
            drive(in_v[i]);
            checks++;
            if (obs !== exp_v[i]) begin
                failures++;
                $display("FAIL reset cycle %0d: got %b expected %b", i, obs, exp_v[i]);
            end
        end
`ifdef SEQ_INSTRET_EN
        checks++;
        if (instret !== 32'd0) begin
            failures++;
            $display("FAIL reset instret: got %0d expected 0", instret);
        end
`endif
    endtask

    task automatic test_r_type();
        logic [4:0]  in_v [5];
        logic [10:0] exp_v[5];
        opcode = OP_R;
        // dmem_ack alongside imem_ack in FETCH and a stray imem_ack in DECODE are ignored
        in_v  = '{5'b01100, 5'b01000, 5'b00000, 5'b00000, 5'b00000};
        exp_v = '{11'b100_1000_0_000, 11'b000_0000_0_001, 11'b000_0000_0_010,
                  11'b000_0110_0_100, 11'b100_0000_0_000};
        for (int i = 0; i < 5; i++) begin
            drive(in_v[i]);
            checks++;
            if (obs !== exp_v[i]) begin
                failures++;
                $display("FAIL r_type cycle %0d: got %b expected %b", i, obs, exp_v[i]);
            end
            if (exp_v[i][5]) exp_retired++;
        end
    endtask

    task automatic test_load_wait();
        logic [4:0]  in_v [9];
        logic [10:0] exp_v[9];
        opcode = OP_LOAD;
        in_v  = '{5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b00000,
                  5'b00000, 5'b00100, 5'b00000, 5'b00000};
        exp_v = '{11'b100_1000_0_000, 11'b000_0000_0_001, 11'b000_0000_0_010,
                  11'b010_0000_0_011, 11'b010_0000_0_011, 11'b010_0000_0_011,
                  11'b010_0000_0_011, 11'b000_0110_0_100, 11'b100_0000_0_000};
        for (int i = 0; i < 9; i++) begin
            drive(in_v[i]);
            checks++;
            if (obs !== exp_v[i]) begin
                failures++;
                $display("FAIL load_wait cycle %0d: got %b expected %b", i, obs, exp_v[i]);
            end
            if (exp_v[i][5]) exp_retired++;
        end
    endtask

    task automatic test_store_stall();
        logic [4:0]  in_v [6];
        logic [10:0] exp_v[6];
        opcode = OP_STORE;
        // stall_in is ignored in MEM
        in_v  = '{5'b01000, 5'b00000, 5'b00000, 5'b00010, 5'b00110, 5'b00000};
        exp_v = '{11'b100_1000_0_000, 11'b000_0000_0_001, 11'b000_0000_0_010,
                  11'b011_0000_0_011, 11'b011_0010_0_011, 11'b100_0000_0_000};
        for (int i = 0; i < 6; i++) begin
            drive(in_v[i]);
            checks++;
            if (obs !== exp_v[i]) begin
                failures++;
                $display("FAIL store cycle %0d: got %b expected %b", i, obs, exp_v[i]);
            end
            if (exp_v[i][5]) exp_retired++;
        end
    endtask

    task automatic test_branch();
        logic [4:0]  in_v [8];
        logic [10:0] exp_v[8];
        opcode = OP_BRANCH;
        in_v  = '{5'b01000, 5'b00001, 5'b00001, 5'b00000,
                  5'b01000, 5'b00000, 5'b00000, 5'b00001};
        exp_v = '{11'b100_1000_0_000, 11'b000_0000_0_001, 11'b000_0011_0_010, 11'b100_0000_0_000,
                  11'b100_1000_0_000, 11'b000_0000_0_001, 11'b000_0010_0_010, 11'b100_0000_0_000};
        for (int i = 0; i < 8; i++) begin
            drive(in_v[i]);
            checks++;
            if (obs !== exp_v[i]) begin
                failures++;
                $display("FAIL branch cycle %0d: got %b expected %b", i, obs, exp_v[i]);
            end
            if (exp_v[i][5]) exp_retired++;
        end
    endtask

    task automatic test_stall_jal();
        logic [4:0]  in_v [9];
        logic [10:0] exp_v[9];
        opcode = OP_JAL;
        in_v  = '{5'b00010, 5'b01010, 5'b00000, 5'b00010, 5'b00010,
                  5'b00000, 5'b00010, 5'b00000, 5'b00000};
        exp_v = '{11'b100_0000_0_000, 11'b100_1000_0_000, 11'b000_0000_0_001,
                  11'b000_0000_0_010, 11'b000_0000_0_010, 11'b000_0000_0_010,
                  11'b000_0000_0_100, 11'b000_0111_0_100, 11'b100_0000_0_000};
        for (int i = 0; i < 9; i++) begin
            drive(in_v[i]);
            checks++;
            if (obs !== exp_v[i]) begin
                failures++;
                $display("FAIL stall_jal cycle %0d: got %b expected %b", i, obs, exp_v[i]);
            end
            if (exp_v[i][5]) exp_retired++;
        end
    endtask

    task automatic test_reset_mid_store();
        logic [4:0]  in_v [7];
        logic [10:0] exp_v[7];
        opcode = OP_STORE;
        in_v  = '{5'b01000, 5'b00000, 5'b00000, 5'b00000, 5'b10000, 5'b00100, 5'b00100};
        exp_v = '{11'b100_1000_0_000, 11'b000_0000_0_001, 11'b000_0000_0_010,
                  11'b011_0000_0_011, 11'b000_0000_0_000, 11'b100_0000_0_000,
                  11'b100_0000_0_000};
        for (int i = 0; i < 7; i++) begin
            drive(in_v[i]);
            checks++;
            if (obs !== exp_v[i]) begin
                failures++;
                $display("FAIL reset_mid_store cycle %0d: got %b expected %b", i, obs, exp_v[i]);
            end
            if (exp_v[i][5]) exp_retired++;
        end
    endtask

    task automatic test_trap();
        logic [6:0] bad_ops [2];
        bad_ops = '{7'b1111111, 7'b0110001};
        for (int k = 0; k < 2; k++) begin
            opcode = bad_ops[k];
            drive(5'b01000);
            drive(5'b00000);
            checks++;
            if (obs !== 11'b000_0000_0_001) begin
                failures++;
                $display("FAIL trap%0d decode: got %b expected %b", k, obs, 11'b000_0000_0_001);
            end
            for (int i = 0; i < 20; i++) begin
                drive(5'b01110);
                checks++;
                if (obs !== 11'b000_0000_1_101) begin
                    failures++;
                    $display("FAIL trap%0d hold cycle %0d: got %b expected %b",
                             k, i, obs, 11'b000_0000_1_101);
                end
            end
            drive(5'b10000);
            checks++;
            if (obs !== 11'b000_0000_0_000) begin
                failures++;
                $display("FAIL trap%0d in_reset: got %b expected %b", k, obs, 11'b000_0000_0_000);
            end
            drive(5'b00000);
            checks++;
            if (obs !== 11'b100_0000_0_000) begin
                failures++;
                $display("FAIL trap%0d after_reset: got %b expected %b", k, obs, 11'b100_0000_0_000);
            end
        end
    endtask

    initial begin
        mem_bus.imem_ack = 1'b0;
        mem_bus.dmem_ack = 1'b0;
        test_reset();
        test_r_type();
        test_load_wait();
        test_store_stall();
        test_branch();
        test_stall_jal();
        test_reset_mid_store();
        test_trap();
`ifdef SEQ_INSTRET_EN
        test_r_type();
        checks++;
        if (instret !== 32'(exp_retired)) begin
            failures++;
            $display("FAIL instret: got %0d expected %0d", instret, exp_retired);
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and write-back, and holds the instruction-memory and data-memory request/acknowledge handshakes. It produces the one-cycle enables that drive the decode stage and PC logic: IR load, register write and PC write. It sits beside the decode stage and replaces free-running single-cycle sequencing, so memories with wait states are supported.

## Interface
Parameters:
- WIDTH, 32, datapath width; sizes the optional retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  instruction[6:0] from the instruction register.
- branch_taken  in  1  branch condition from the ALU, valid in EXECUTE.
- stall_in  in  1  external hold request.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch complete; instruction valid this cycle.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  store when high, load when low; valid only with dmem_req.
- dmem_ack  in  1  data access complete.
- ir_load  out  1  latch instruction register.
- reg_write  out  1  register file write enable.
- pc_write  out  1  update PC.
- pc_src  out  1  0 = PC+4, 1 = branch/jump target.
- illegal  out  1  sticky illegal-opcode flag.
- state  out  3  current state encoding, for debug.

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir_load=1 the same cycle, then go to DECODE.
- DECODE:
  - Classify opcode into R, I_ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI or AUIPC.
  - Register the class.
  - Unknown opcode (including opcode[1:0]≠2'b11) goes to TRAP; otherwise go to EXECUTE.
- EXECUTE:
  - LOAD and STORE go to MEM.
  - BRANCH: pc_write=1 and pc_src=branch_taken, then go to FETCH.
  - All other classes go to WRITEBACK.
- MEM:
  - dmem_req=1; dmem_we=1 only for STORE.
  - On dmem_ack, LOAD goes to WRITEBACK.
  - On dmem_ack, STORE asserts pc_write=1 with pc_src=0, then goes to FETCH.
- WRITEBACK:
  - reg_write=1 and pc_write=1.
  - pc_src=1 for JAL/JALR, 0 otherwise.
  - Go to FETCH.
- TRAP: all enables and requests are 0 and illegal=1. Only rst exits TRAP.
- imem_req, dmem_req, dmem_we and state are Moore outputs (state and registered class only).
- ir_load, reg_write, pc_write and pc_src are single-cycle Mealy pulses.
- A request stays high until its ack arrives. An ack received while its request is low is ignored.
- stall_in is honoured only in DECODE, EXECUTE and WRITEBACK. There it freezes the state and forces ir_load, reg_write and pc_write to 0.
- stall_in is ignored in FETCH and MEM, so an in-flight handshake always completes.

## Timing
- Reset:
  - While rst is high, every output is 0.
  - State resets to FETCH, class to R, illegal to 0.
  - imem_req rises in the first cycle after rst falls.
- Latency with zero-wait memories (ack in the first request cycle), in cycles:
  - R, I_ALU, LUI, AUIPC, JAL, JALR: 4.
  - LOAD: 5.
  - STORE: 4.
  - BRANCH: 3.
- Each memory wait cycle adds one cycle. Each stalled cycle adds one cycle.
- rst mid-handshake: requests drop the same cycle and a fresh FETCH restarts. Late acks are ignored under the ack rule above.
- imem_ack and dmem_ack high together: only the ack matching the current state is used.

## Configuration
- SEQ_INSTRET_EN defined:
  - Adds output instret [WIDTH-1:0].
  - Increments by 1 on every cycle where pc_write=1 (retired instruction) and wraps modulo 2^WIDTH.
  - Reset value is 0.
  - Holds in TRAP.
- SEQ_INSTRET_EN undefined: the port and counter do not exist. All other behaviour is identical.

## Structure
- Shared package cpu_pkg holds:
  - the RV32I opcode localparams (OP_R 7'b0110011, OP_IMM 7'b0010011, OP_LOAD 7'b0000011, OP_STORE 7'b0100011, OP_BRANCH 7'b1100011, OP_JAL 7'b1101111, OP_JALR 7'b1100111, OP_LUI 7'b0110111, OP_AUIPC 7'b0010111);
  - the 3-bit state encoding (FETCH=0 … TRAP=5);
  - the instruction class encoding.
- Sub-module opcode_classifier: combinational, opcode → class and illegal.

## Test plan
- R-type (0110011), imem_ack in the first FETCH cycle → ir_load at cycle 0, reg_write and pc_write together at cycle 3 with pc_src=0, imem_req high again at cycle 4.
- Load with dmem_ack delayed 3 cycles → dmem_req held 4 cycles with dmem_we=0, then reg_write for one cycle; 8 cycles total.
- Branch: branch_taken=1 → pc_write with pc_src=1 in EXECUTE. branch_taken=0 → pc_src=0. No reg_write in either case.
- stall_in held 2 cycles in EXECUTE of JAL → state frozen, no pulses; then WRITEBACK with pc_src=1. stall_in during FETCH wait → ignored.
- Opcode 7'b1111111 → TRAP, illegal=1 and all requests 0 for 20 cycles; rst → FETCH with illegal=0.
- rst asserted during MEM with a store pending → dmem_req=0 the next cycle; a dmem_ack arriving later is ignored.
